// File: rtl/traffic_pkg.sv
// Shared definitions for the count-pattern traffic generator and checker:
// FSM state encoding plus modulus/width/next-value helpers for the pattern.
package traffic_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_TRACK   = 2'd2
   } state_e;

   localparam int DATA_W = 32;

   function automatic logic [32:0] modulus(input logic [31:0] high);
      return {1'b0, high} + 33'd1;
   endfunction

   function automatic int count_width(input logic [31:0] high);
      return $clog2(modulus(high));
   endfunction

   function automatic logic [31:0] next_count(input logic [31:0] v, input logic [31:0] high);
      return (v == high) ? 32'd0 : v + 32'd1;
   endfunction

endpackage

// File: rtl/traffic_checker_if.sv
// AXI4-Stream data channel between a count-pattern source and the checker.
// The sink's tready is purely combinational from its enable; no tlast/tkeep.
interface traffic_checker_if;
   import traffic_pkg::*;

   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/traffic_checker_sat_counter.sv
// Saturating statistics counter: adds inc_i each cycle, clamps at all-ones.
// One-cycle latency; synchronous clear has priority over the increment.
module sat_counter #(
   parameter int WIDTH = 32,
   parameter int INC_W = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clear_i,
   input  logic [INC_W-1:0] inc_i,
   output logic [WIDTH-1:0] count_o
);

   localparam int SUM_W = ((WIDTH > INC_W) ? WIDTH : INC_W) + 1;

   logic [WIDTH-1:0] count_q, count_d;
   logic [SUM_W-1:0] sum;

   always_comb begin
      sum     = SUM_W'(count_q) + SUM_W'(inc_i);
      count_d = (|sum[SUM_W-1:WIDTH]) ? '1 : sum[WIDTH-1:0];
      if (clear_i) count_d = '0;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) count_q <= '0;
      else         count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/traffic_checker.sv
// AXI4-Stream sink verifying an incrementing count pattern; full rate, stats 1 cycle after accept.
// tready follows enable only (never tvalid), so the source is never throttled while enabled.
module traffic_checker
   import traffic_pkg::*;
#(
   parameter logic [31:0] COUNT_HIGH = 32'hFFFF_FFFF,
   parameter int          STAT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  enable,
   input  logic                  freerun,
   input  logic                  clear,
   traffic_checker_if.slave      axis,
   output logic                  locked,
   output logic                  error,
   output logic [STAT_WIDTH-1:0] beat_count,
   output logic [STAT_WIDTH-1:0] error_count,
   output logic [STAT_WIDTH-1:0] gap_count,
   output logic [STAT_WIDTH-1:0] missed_count,
   output logic [31:0]           last_data
);

   localparam logic [32:0] M = modulus(COUNT_HIGH);

   state_e      state_q, state_d;
   logic [31:0] expected_q, expected_d;
   logic [31:0] last_data_q;
   logic        error_q;
   logic        accept, out_of_range, err_inc, gap_inc;
   logic [32:0] gap_dist, miss_inc;

   assign axis.tready  = enable & resetn;
   assign accept       = axis.tvalid & axis.tready;
   assign out_of_range = axis.tdata > COUNT_HIGH;
   // Forward distance modulo M; only meaningful when both values are in range.
   assign gap_dist = (axis.tdata >= expected_q) ? {1'b0, axis.tdata - expected_q}
                                                : M - {1'b0, expected_q - axis.tdata};

   always_comb begin
      state_d    = state_q;
      expected_d = expected_q;
      err_inc    = 1'b0;
      gap_inc    = 1'b0;
      miss_inc   = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_ACQUIRE;
         end
         ST_ACQUIRE: begin
            if (accept) begin
               if (out_of_range) begin
                  err_inc = 1'b1;
               end else begin
                  expected_d = next_count(axis.tdata, COUNT_HIGH);
                  state_d    = ST_TRACK;
               end
            end
         end
         ST_TRACK: begin
            if (accept) begin
               if (out_of_range) begin
                  err_inc    = 1'b1;
                  expected_d = next_count(expected_q, COUNT_HIGH);
               end else begin
                  expected_d = next_count(axis.tdata, COUNT_HIGH);
                  if (axis.tdata != expected_q) begin
                     if (freerun) begin
                        gap_inc  = 1'b1;
                        miss_inc = gap_dist;
                     end else begin
                        err_inc = 1'b1;
                     end
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (!enable) state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= ST_IDLE;
         expected_q  <= '0;
         last_data_q <= '0;
         error_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         expected_q <= expected_d;
         if (accept) last_data_q <= axis.tdata;
         if (clear)        error_q <= 1'b0;
         else if (err_inc) error_q <= 1'b1;
      end
   end

   sat_counter #(.WIDTH(STAT_WIDTH), .INC_W(1)) u_beat_cnt (
      .clk(clk), .resetn(resetn), .clear_i(clear), .inc_i(accept), .count_o(beat_count)
   );

   sat_counter #(.WIDTH(STAT_WIDTH), .INC_W(1)) u_error_cnt (
      .clk(clk), .resetn(resetn), .clear_i(clear), .inc_i(err_inc), .count_o(error_count)
   );

   sat_counter #(.WIDTH(STAT_WIDTH), .INC_W(1)) u_gap_cnt (
      .clk(clk), .resetn(resetn), .clear_i(clear), .inc_i(gap_inc), .count_o(gap_count)
   );

   sat_counter #(.WIDTH(STAT_WIDTH), .INC_W(33)) u_missed_cnt (
      .clk(clk), .resetn(resetn), .clear_i(clear), .inc_i(miss_inc), .count_o(missed_count)
   );

   assign locked    = (state_q == ST_TRACK);
   assign error     = error_q;
   assign last_data = last_data_q;

endmodule

// File: tb/tb_traffic_checker.sv
// Bench for traffic_checker with a 16-value pattern and 4-bit saturating statistics.
module tb_traffic_checker;

   localparam int M   = 16;
   localparam int SAT = 15;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        enable = 1'b0;
   logic        freerun = 1'b0;
   logic        clear = 1'b0;
   logic        locked, error;
   logic [3:0]  beat_count, error_count, gap_count, missed_count;
   logic [31:0] last_data;

   traffic_checker_if axis();

   traffic_checker #(.COUNT_HIGH(32'd15), .STAT_WIDTH(4)) dut (
      .clk(clk), .resetn(resetn), .enable(enable), .freerun(freerun), .clear(clear),
      .axis(axis), .locked(locked), .error(error),
      .beat_count(beat_count), .error_count(error_count),
      .gap_count(gap_count), .missed_count(missed_count), .last_data(last_data)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: armed = enabled past the idle cycle, locked = reference acquired.
   bit          m_armed, m_locked, m_err;
   int          m_exp, m_beat, m_errc, m_gap, m_miss;
   logic [31:0] m_last;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v > SAT) ? SAT : v;
   endfunction

   task automatic model_step();
      int b, e, g, d;
      if (!resetn) begin
         m_armed = 0; m_locked = 0; m_err = 0; m_exp = 0;
         m_beat = 0; m_errc = 0; m_gap = 0; m_miss = 0; m_last = '0;
         return;
      end
      b = 0; e = 0; g = 0; d = 0;
      if (axis.tvalid && enable) begin
         b = 1;
         m_last = axis.tdata;
         if (m_armed) begin
            if (axis.tdata > 15) begin
               e = 1;
               if (m_locked) m_exp = (m_exp + 1) % M;
            end else begin
               if (m_locked && int'(axis.tdata) != m_exp) begin
                  if (freerun) begin
                     g = 1;
                     d = (int'(axis.tdata) - m_exp + M) % M;
                  end else begin
                     e = 1;
                  end
               end
               m_locked = 1;
               m_exp = (int'(axis.tdata) + 1) % M;
            end
         end
      end
      if (clear) begin
         m_beat = 0; m_errc = 0; m_gap = 0; m_miss = 0; m_err = 0;
      end else begin
         m_beat = sat(m_beat + b);
         m_errc = sat(m_errc + e);
         m_gap  = sat(m_gap + g);
         m_miss = sat(m_miss + d);
         if (e != 0) m_err = 1;
      end
      if (!enable) begin
         m_armed = 0; m_locked = 0;
      end else begin
         m_armed = 1;
      end
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      check("tready", 32'(axis.tready), 32'(enable & resetn));
      check("locked", 32'(locked), 32'(m_locked));
      check("error", 32'(error), 32'(m_err));
      check("beat_count", 32'(beat_count), 32'(m_beat));
      check("error_count", 32'(error_count), 32'(m_errc));
      check("gap_count", 32'(gap_count), 32'(m_gap));
      check("missed_count", 32'(missed_count), 32'(m_miss));
      check("last_data", last_data, m_last);
   end

   task automatic send(input logic [31:0] d);
      axis.tdata  = d;
      axis.tvalid = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_clear();
      axis.tvalid = 1'b0;
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic reacquire();
      axis.tvalid = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      check("lit_locked_falls", 32'(locked), 32'd0);
      enable = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      axis.tvalid = 1'b0;
      axis.tdata  = '0;
      repeat (2) @(negedge clk);
      check("lit_rst_tready", 32'(axis.tready), 32'd0);
      check("lit_rst_locked", 32'(locked), 32'd0);
      check("lit_rst_beat", 32'(beat_count), 32'd0);
      check("lit_rst_last", last_data, 32'd0);

      // Continuous 5..15,0,1 with wrap
      resetn = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      send(32'd5);
      check("lit_locked_first", 32'(locked), 32'd1);
      for (int v = 6; v <= 17; v++) send(32'(v % 16));
      axis.tvalid = 1'b0;
      check("lit_p1_beat", 32'(beat_count), 32'd13);
      check("lit_p1_errc", 32'(error_count), 32'd0);
      check("lit_p1_last", last_data, 32'd1);

      // Strict mode jump
      do_clear();
      reacquire();
      freerun = 1'b0;
      send(32'd0); send(32'd1); send(32'd2); send(32'd7); send(32'd8); send(32'd9);
      axis.tvalid = 1'b0;
      check("lit_p2_beat", 32'(beat_count), 32'd6);
      check("lit_p2_errc", 32'(error_count), 32'd1);
      check("lit_p2_error", 32'(error), 32'd1);
      check("lit_p2_gap", 32'(gap_count), 32'd0);

      // Freerun gaps, backward jump and missed-count clamp
      do_clear();
      reacquire();
      freerun = 1'b1;
      send(32'd0); send(32'd1); send(32'd2); send(32'd7);
      axis.tvalid = 1'b0;
      check("lit_p3_gap1", 32'(gap_count), 32'd1);
      check("lit_p3_miss1", 32'(missed_count), 32'd4);
      send(32'd3);
      check("lit_p3_miss2", 32'(missed_count), 32'd15);
      send(32'd4); send(32'd10);
      axis.tvalid = 1'b0;
      check("lit_p3_gap3", 32'(gap_count), 32'd3);
      check("lit_p3_miss3", 32'(missed_count), 32'd15);
      check("lit_p3_errc", 32'(error_count), 32'd0);

      // Out-of-range while tracking and while acquiring
      do_clear();
      send(32'd11); send(32'd20); send(32'd13); send(32'd14);
      axis.tvalid = 1'b0;
      check("lit_p4_errc", 32'(error_count), 32'd1);
      check("lit_p4_gap", 32'(gap_count), 32'd0);
      check("lit_p4_beat", 32'(beat_count), 32'd4);
      reacquire();
      send(32'h8000_0003);
      check("lit_p4_acq_locked", 32'(locked), 32'd0);
      send(32'd3); send(32'd4);
      axis.tvalid = 1'b0;
      check("lit_p4_relock", 32'(locked), 32'd1);
      check("lit_p4_errc2", 32'(error_count), 32'd2);

      // Saturation and clear colliding with a beat
      freerun = 1'b0;
      do_clear();
      for (int i = 0; i < 20; i++) send(32'((5 + i) % 16));
      axis.tvalid = 1'b0;
      check("lit_p5_beat_sat", 32'(beat_count), 32'd15);
      clear = 1'b1;
      send(32'd0);
      clear = 1'b0;
      axis.tvalid = 1'b0;
      check("lit_p5_clr_beat", 32'(beat_count), 32'd0);
      check("lit_p5_clr_error", 32'(error), 32'd0);
      send(32'd1);
      axis.tvalid = 1'b0;
      check("lit_p5_after_clr", 32'(beat_count), 32'd1);
      for (int i = 0; i < 17; i++) send(32'd5);
      axis.tvalid = 1'b0;
      check("lit_p5_errc_sat", 32'(error_count), 32'd15);
      do_clear();

      // Reset mid-stream
      send(32'd6); send(32'd7);
      axis.tdata = 32'd8;
      resetn = 1'b0;
      #1;
      check("lit_p6_async_beat", 32'(beat_count), 32'd0);
      check("lit_p6_async_last", last_data, 32'd0);
      @(negedge clk);
      axis.tvalid = 1'b0;
      enable = 1'b0;
      resetn = 1'b1;
      @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      send(32'd12); send(32'd13);
      axis.tvalid = 1'b0;
      check("lit_p6_errc", 32'(error_count), 32'd0);
      check("lit_p6_beat", 32'(beat_count), 32'd2);
      check("lit_p6_locked", 32'(locked), 32'd1);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
